// File: rtl/adder_pkg.sv
// Shared types and helpers for pipelined_chunk_adder and its slice stages.
// PIPE_CHUNK_ADDER_OVF_EN (optional) enables the signed-overflow output.
package adder_pkg;

  // Upper bound on WIDTH, so that the stage record can be one fixed type.
  localparam int MAX_WIDTH = 64;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int cw(input int width, input int chunks);
    return width / chunks;
  endfunction

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [MAX_WIDTH-1:0] psum;
    logic [MAX_WIDTH-1:0] a_rem;
    logic [MAX_WIDTH-1:0] b_rem;
  } stage_t;

endpackage

// File: rtl/pipelined_chunk_adder_if.sv
// Operand/result handshake bus of pipelined_chunk_adder.
// PIPE_CHUNK_ADDER_OVF_EN adds the registered signed-overflow flag ovf.
interface pipelined_chunk_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef PIPE_CHUNK_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
`ifdef PIPE_CHUNK_ADDER_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
`ifdef PIPE_CHUNK_ADDER_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/adder_chunk_stage.sv
// One registered CW-bit slice adder stage with valid bit and hold enable.
// PIPE_CHUNK_ADDER_OVF_EN adds c_msb, the registered carry into the slice MSB.
module adder_chunk_stage #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
`ifdef PIPE_CHUNK_ADDER_OVF_EN
  output logic          c_msb,
`endif
  output logic          out_valid,
  output logic [CW-1:0] sum,
  output logic          cout
);

  logic [CW:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (CW+1)'(cin);

  // Data only moves on a valid word, so a bubble never disturbs the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef PIPE_CHUNK_ADDER_OVF_EN
      c_msb     <= 1'b0;
`endif
    end else if (en) begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= total[CW-1:0];
        cout  <= total[CW];
`ifdef PIPE_CHUNK_ADDER_OVF_EN
        c_msb <= a[CW-1] ^ b[CW-1] ^ total[CW-1];
`endif
      end
    end
  end

endmodule

// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/subtract: one CW-bit slice per stage, carry rippled stage to stage.
// PIPE_CHUNK_ADDER_OVF_EN adds the signed-overflow output ovf on the bus.
module pipelined_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CHUNKS = 4
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_chunk_adder_if.slave bus
);

  localparam int CW = cw(WIDTH, CHUNKS);

  if (CHUNKS < 1 || CHUNKS > WIDTH) begin : g_bad_chunks
    $error("pipelined_chunk_adder: CHUNKS must be in 1..WIDTH");
  end
  if (WIDTH % CHUNKS != 0) begin : g_bad_split
    $error("pipelined_chunk_adder: WIDTH must be a multiple of CHUNKS");
  end
  if (WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("pipelined_chunk_adder: WIDTH exceeds adder_pkg::MAX_WIDTH");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  logic             v   [CHUNKS];
  logic             c   [CHUNKS];
  logic [CW-1:0]    s   [CHUNKS];
  logic [WIDTH-1:0] opa [CHUNKS];
  logic [WIDTH-1:0] opb [CHUNKS];
  logic [WIDTH-1:0] fwd [CHUNKS];
  stage_t           st  [CHUNKS];

  // Subtraction is a + ~b + !borrow, so the inversion happens once at the input.
  assign b_eff   = (bus.sub == SUB) ? ~bus.b : bus.b;
  assign cin_eff = (bus.sub == SUB) ? ~bus.cin : bus.cin;

  assign advance      = !v[CHUNKS-1] || bus.out_ready;
  assign bus.in_ready = advance;

  // Stage k view: completed low slices plus this slice, and the operand still to be summed.
  always_comb begin
    for (int k = 0; k < CHUNKS; k++) begin
      st[k]                    = '0;
      st[k].valid              = v[k];
      st[k].carry              = c[k];
      st[k].psum[WIDTH-1:0]    = fwd[k];
      st[k].psum[k*CW +: CW]   = s[k];
      st[k].a_rem[WIDTH-1:0]   = opa[k];
      st[k].b_rem[WIDTH-1:0]   = opb[k];
    end
  end

  // Skew (upper operand slices) and forwarding (finished low slices) registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHUNKS; k++) begin
        opa[k] <= '0;
        opb[k] <= '0;
        fwd[k] <= '0;
      end
    end else if (advance) begin
      if (bus.in_valid) begin
        opa[0] <= bus.a;
        opb[0] <= b_eff;
      end
      for (int k = 1; k < CHUNKS; k++) begin
        if (st[k-1].valid) begin
          opa[k] <= st[k-1].a_rem[WIDTH-1:0];
          opb[k] <= st[k-1].b_rem[WIDTH-1:0];
          fwd[k] <= st[k-1].psum[WIDTH-1:0];
        end
      end
    end
  end

`ifdef PIPE_CHUNK_ADDER_OVF_EN
  logic cm [CHUNKS];
`endif

  for (genvar k = 0; k < CHUNKS; k++) begin : g_stage
    logic          sv;
    logic          sc;
    logic [CW-1:0] sa;
    logic [CW-1:0] sb;

    if (k == 0) begin : g_head
      assign sv = bus.in_valid;
      assign sa = bus.a[CW-1:0];
      assign sb = b_eff[CW-1:0];
      assign sc = cin_eff;
    end else begin : g_tail
      assign sv = st[k-1].valid;
      assign sa = st[k-1].a_rem[k*CW +: CW];
      assign sb = st[k-1].b_rem[k*CW +: CW];
      assign sc = st[k-1].carry;
    end

    adder_chunk_stage #(
      .CW(CW)
    ) u_chunk (
      .clk       (clk),
      .rst       (rst),
      .en        (advance),
      .in_valid  (sv),
      .a         (sa),
      .b         (sb),
      .cin       (sc),
`ifdef PIPE_CHUNK_ADDER_OVF_EN
      .c_msb     (cm[k]),
`endif
      .out_valid (v[k]),
      .sum       (s[k]),
      .cout      (c[k])
    );
  end

  assign bus.out_valid = v[CHUNKS-1];
  assign bus.sum       = st[CHUNKS-1].psum[WIDTH-1:0];
  assign bus.cout      = c[CHUNKS-1];

`ifdef PIPE_CHUNK_ADDER_OVF_EN
  // Overflow when the carry into the MSB differs from the carry out of it.
  assign bus.ovf = cm[CHUNKS-1] ^ c[CHUNKS-1];
`endif

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed-vector bench for pipelined_chunk_adder (WIDTH=16, CHUNKS=4).
// Checks ovf as well when PIPE_CHUNK_ADDER_OVF_EN is defined.
module tb_pipelined_chunk_adder;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipelined_chunk_adder_if #(.WIDTH(16)) bus ();

  pipelined_chunk_adder #(
    .WIDTH  (16),
    .CHUNKS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic sub);
    if (sub)
      return {1'b0, a} + {1'b0, ~b} + 17'(!cin);
    else
      return {1'b0, a} + {1'b0, b} + 17'(cin);
  endfunction

  // Single operation: accept, wait for the result, check latency and value.
  task automatic applyStimulus(input vec_t v);
    int wait_cycles;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.cin       = v.cin;
    bus.sub       = v.sub;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checkOutput({v.name, "_accept"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_cycles = 0;
    while (!bus.out_valid && wait_cycles < 20) begin
      @(posedge clk); #1;
      wait_cycles++;
    end
    checkOutput({v.name, "_latency"}, 32'(wait_cycles), 32'd3);
    checkOutput({v.name, "_sum"}, 32'(bus.sum), 32'(v.exp_sum));
    checkOutput({v.name, "_cout"}, 32'(bus.cout), 32'(v.exp_cout));
`ifdef PIPE_CHUNK_ADDER_OVF_EN
    checkOutput({v.name, "_ovf"}, 32'(bus.ovf), 32'(v.exp_ovf));
`endif
  endtask

  vec_t        vecs [12];
  logic [15:0] st_a   [8];
  logic [15:0] st_b   [8];
  logic        st_cin [8];
  logic        st_sub [8];

  initial begin
    int          sent;
    int          recv;
    int          stale;
    logic        acc;
    logic        held;
    logic [15:0] held_sum;
    logic [16:0] exp_full;
    vec_t        post;

    vecs[0]  = '{"add_slice_carry", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{"add_full_ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{"sub_borrow",      16'h0005, 16'h0009, 1'b0, 1'b1, 16'hFFFC, 1'b0, 1'b0};
    vecs[3]  = '{"sub_borrow_in",   16'h0009, 16'h0005, 1'b1, 1'b1, 16'h0003, 1'b1, 1'b0};
    vecs[4]  = '{"add_pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5]  = '{"sub_neg_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6]  = '{"add_small",       16'h0004, 16'h0008, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0};
    vecs[7]  = '{"add_mixed",       16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    vecs[8]  = '{"sub_zero",        16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{"add_all_ones",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[10] = '{"sub_wrap",        16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[11] = '{"add_neg_ovf",     16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

    total = 0;
    bad   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_sum", 32'(bus.sum), 32'd0);
    checkOutput("rst_cout", 32'(bus.cout), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
`ifdef PIPE_CHUNK_ADDER_OVF_EN
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);
`endif

    $display("[TB] directed vectors");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);
    @(posedge clk); #1;

    $display("[TB] stream with mid-stream stall");
    for (int i = 0; i < 8; i++) begin
      st_a[i]   = 16'($urandom_range(0, 65535));
      st_b[i]   = 16'($urandom_range(0, 65535));
      st_cin[i] = 1'($urandom_range(0, 1));
      st_sub[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;
    recv = 0;
    held = 1'b0;
    held_sum = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      bus.out_ready = !(cyc >= 6 && cyc < 9);
      if (sent < 8) begin
        bus.in_valid = 1'b1;
        bus.a        = st_a[sent];
        bus.b        = st_b[sent];
        bus.cin      = st_cin[sent];
        bus.sub      = st_sub[sent];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checkOutput("stall_valid_hold", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_sum_stable", 32'(bus.sum), 32'(held_sum));
      end
      if (bus.out_valid && !bus.out_ready)
        checkOutput("stall_in_ready", 32'(bus.in_ready), 32'd0);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        exp_full = model(st_a[recv], st_b[recv], st_cin[recv], st_sub[recv]);
        checkOutput("stream_sum", 32'(bus.sum), 32'(exp_full[15:0]));
        checkOutput("stream_cout", 32'(bus.cout), 32'(exp_full[16]));
        recv++;
      end
      held     = bus.out_valid && !bus.out_ready;
      held_sum = bus.sum;
      @(posedge clk); #1;
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("stream_count", 32'(recv), 32'd8);
    #1;
    checkOutput("stream_drained", 32'(bus.out_valid), 32'd0);

    $display("[TB] reset with operations in flight");
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      bus.cin      = vecs[i].cin;
      bus.sub      = vecs[i].sub;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_sum", 32'(bus.sum), 32'd0);
    checkOutput("midrst_cout", 32'(bus.cout), 32'd0);
    stale = 0;
    repeat (6) begin
      if (bus.out_valid) stale++;
      @(posedge clk); #1;
    end
    checkOutput("midrst_no_stale", 32'(stale), 32'd0);
    post = '{"post_reset", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    applyStimulus(post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
